// File: rtl/segments_decoder.sv
// Recovers a byte from a multiplexed 7-segment display bus by qualifying each
// digit for STABLE_CYCLES samples and pairing the low and high hex nibbles.
module segments_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_data,
  input  logic [3:0] seg_digit,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

  // Segment order a..g, index = hex value of the glyph.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef enum logic {S_LO, S_HI} state_t;

  logic [11:0]   cur_in;
  logic [11:0]   in_q, in_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  state_t        state_q, state_d;
  logic [3:0]    lo_q, lo_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [6:0]    lit;
  logic [15:0]   match;
  logic          hit;
  logic [3:0]    nib;
  logic          is_lo, is_hi, is_blank;

  assign cur_in = {seg_digit, seg_data};

  always_comb begin
    in_d = cur_in;
    if (cur_in != in_q)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + CW'(1);
    else
      cnt_d = cnt_q;
  end

  // Counter saturates past CNT_ACC, so a held input is accepted only once.
  assign accept = (cur_in == in_q) && (cnt_q == CNT_ACC);

  assign lit      = ~in_q[7:1];
  assign is_lo    = (in_q[11:8] == 4'b1110);
  assign is_hi    = (in_q[11:8] == 4'b1101);
  assign is_blank = (in_q[11:8] == 4'b1011) || (in_q[11:8] == 4'b0111);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_match
      assign match[gi] = (lit == GLYPH[gi]);
    end
  endgenerate

  assign hit = |match;

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (match[i]) nib = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= 12'hFFF;
      cnt_q   <= '0;
      state_q <= S_LO;
      lo_q    <= 4'h0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if ((is_lo || is_hi) && !hit) begin
        state_d = S_LO;
      end else begin
        case (state_q)
          S_LO: if (is_lo) state_d = S_HI;
          S_HI: if (is_hi || is_blank) state_d = S_LO;
          default: state_d = S_LO;
        endcase
      end
    end
  end

  always_comb begin
    lo_d    = lo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if ((is_lo || is_hi) && !hit) begin
        err_d = 1'b1;
      end else if (is_lo) begin
        lo_d = nib;
      end else if (is_hi && state_q == S_HI) begin
        data_d  = {nib, lo_q};
        valid_d = 1'b1;
      end
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_segments_decoder.sv
// Randomized and directed bench for segments_decoder against a run-length
// based reference model of the display-capture rules.
module tb_segments_decoder;

  localparam int STABLE = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg_data = 8'hFF;
  logic [3:0] seg_digit = 4'hF;
  logic [7:0] data;
  logic       valid;
  logic       err;

  segments_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_data(seg_data), .seg_digit(seg_digit),
    .data(data), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  logic [6:0] glyphs [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int vcount   = 0;
  int ecount   = 0;
  bit chk_en   = 1'b0;

  // Reference model: a digit is taken once it has been sampled STABLE+1 times in a row.
  logic [11:0] m_last;
  int          m_run;
  bit          m_hi;
  logic [3:0]  m_lo;
  logic [7:0]  m_data;
  logic        m_valid, m_err;

  initial begin
    logic [11:0] cur;
    logic [6:0]  p;
    int          idx;
    m_last = 12'hFFF; m_run = 1; m_hi = 0; m_lo = 0;
    m_data = 8'h00; m_valid = 0; m_err = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_last = 12'hFFF; m_run = 1; m_hi = 0; m_lo = 0;
        m_data = 8'h00; m_valid = 0; m_err = 0;
      end else begin
        cur = {seg_digit, seg_data};
        m_valid = 0;
        m_err = 0;
        if (cur == m_last) begin
          if (m_run < STABLE + 2) m_run = m_run + 1;
        end else begin
          m_last = cur;
          m_run = 1;
        end
        if (m_run == STABLE + 1) begin
          p = ~cur[7:1];
          idx = -1;
          for (int i = 0; i < 16; i++) if (p == glyphs[i]) idx = i;
          if ((cur[11:8] == 4'b1110 || cur[11:8] == 4'b1101) && idx < 0) begin
            m_err = 1; m_hi = 0;
          end else if (cur[11:8] == 4'b1110) begin
            m_lo = 4'(idx); m_hi = 1;
          end else if (cur[11:8] == 4'b1101) begin
            if (m_hi) begin
              m_data = {4'(idx), m_lo}; m_valid = 1; m_hi = 0;
            end
          end else if (cur[11:8] == 4'b1011 || cur[11:8] == 4'b0111) begin
            m_hi = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk_cnt++;
        if (data !== m_data) $display("FAIL cyc_data: got %h expected %h", data, m_data);
        else pass_cnt++;
        chk_cnt++;
        if (valid !== m_valid) $display("FAIL cyc_valid: got %b expected %b", valid, m_valid);
        else pass_cnt++;
        chk_cnt++;
        if (err !== m_err) $display("FAIL cyc_err: got %b expected %b", err, m_err);
        else pass_cnt++;
        chk_cnt++;
        if ((valid & err) !== 1'b0) $display("FAIL cyc_excl: valid&err got %b expected 0", valid & err);
        else pass_cnt++;
        if (valid === 1'b1) vcount++;
        if (err === 1'b1) ecount++;
      end
    end
  end

  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    @(negedge clk);
    seg_digit = d;
    seg_data  = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; seg_digit = 4'hF; seg_data = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk_cnt++;
    if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else pass_cnt++;
    chk_cnt++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else pass_cnt++;
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
    rst = 1'b0;
    $display("test_reset: data=%h valid=%b err=%b", data, valid, err);
  endtask

  task automatic test_basic();
    int v = 0, first = -1;
    reset_dut();
    hold(4'b1110, 8'h49, 40);
    @(negedge clk);
    seg_digit = 4'b1101; seg_data = 8'h11;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin v++; if (first < 0) first = k; end
    end
    chk_cnt++;
    if (v !== 1) $display("FAIL basic_count: got %0d expected 1", v); else pass_cnt++;
    chk_cnt++;
    if (first !== STABLE) $display("FAIL basic_edge: got %0d expected %0d", first, STABLE); else pass_cnt++;
    chk_cnt++;
    if (data !== 8'hA5) $display("FAIL basic_data: got %h expected a5", data); else pass_cnt++;
    $display("test_basic: pulses=%0d edge=%0d data=%h", v, first, data);
  endtask

  task automatic test_rotation();
    int v0, e0;
    reset_dut();
    v0 = vcount; e0 = ecount;
    repeat (3) begin
      hold(4'b1110, 8'h49, 40);
      hold(4'b1101, 8'h11, 40);
      hold(4'b1011, 8'h71, 40);
      hold(4'b0111, 8'h71, 40);
    end
    chk_cnt++;
    if (vcount - v0 !== 3) $display("FAIL rot_valid: got %0d expected 3", vcount - v0); else pass_cnt++;
    chk_cnt++;
    if (ecount - e0 !== 0) $display("FAIL rot_err: got %0d expected 0", ecount - e0); else pass_cnt++;
    chk_cnt++;
    if (data !== 8'hA5) $display("FAIL rot_data: got %h expected a5", data); else pass_cnt++;
    $display("test_rotation: pulses=%0d errs=%0d data=%h", vcount - v0, ecount - e0, data);
  endtask

  task automatic test_short_high();
    int v0;
    reset_dut();
    v0 = vcount;
    hold(4'b1110, 8'h49, 40);
    hold(4'b1101, 8'h11, 10);
    hold(4'b1011, 8'h71, 40);
    chk_cnt++;
    if (vcount - v0 !== 0) $display("FAIL short_valid: got %0d expected 0", vcount - v0); else pass_cnt++;
    hold(4'b1101, 8'h11, 40);
    chk_cnt++;
    if (vcount - v0 !== 0) $display("FAIL short_state: got %0d expected 0", vcount - v0); else pass_cnt++;
    chk_cnt++;
    if (data !== 8'h00) $display("FAIL short_data: got %h expected 00", data); else pass_cnt++;
    $display("test_short_high: pulses=%0d data=%h", vcount - v0, data);
  endtask

  task automatic test_bad_low();
    int v0, e0;
    reset_dut();
    v0 = vcount; e0 = ecount;
    hold(4'b1110, 8'hFF, 40);
    chk_cnt++;
    if (ecount - e0 !== 1) $display("FAIL bad_err: got %0d expected 1", ecount - e0); else pass_cnt++;
    chk_cnt++;
    if (vcount - v0 !== 0) $display("FAIL bad_valid: got %0d expected 0", vcount - v0); else pass_cnt++;
    hold(4'b1110, 8'h49, 40);
    hold(4'b1101, 8'h11, 40);
    chk_cnt++;
    if (vcount - v0 !== 1) $display("FAIL bad_recover: got %0d expected 1", vcount - v0); else pass_cnt++;
    chk_cnt++;
    if (data !== 8'hA5) $display("FAIL bad_data: got %h expected a5", data); else pass_cnt++;
    $display("test_bad_low: errs=%0d pulses=%0d data=%h", ecount - e0, vcount - v0, data);
  endtask

  task automatic test_dp_glitch();
    int v0;
    reset_dut();
    v0 = vcount;
    hold(4'b1110, 8'h48, 40);
    hold(4'b1101, 8'h10, 8);
    hold(4'b1101, 8'h11, 1);
    hold(4'b1101, 8'h10, 40);
    chk_cnt++;
    if (vcount - v0 !== 1) $display("FAIL glitch_count: got %0d expected 1", vcount - v0); else pass_cnt++;
    chk_cnt++;
    if (data !== 8'hA5) $display("FAIL glitch_data: got %h expected a5", data); else pass_cnt++;
    $display("test_dp_glitch: pulses=%0d data=%h", vcount - v0, data);
  endtask

  task automatic test_reset_mid();
    int v0;
    reset_dut();
    v0 = vcount;
    hold(4'b1110, 8'h49, STABLE + 1);
    @(negedge clk);
    rst = 1'b1; seg_digit = 4'b1101; seg_data = 8'h11;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk_cnt++;
    if (vcount - v0 !== 0) $display("FAIL midrst_valid: got %0d expected 0", vcount - v0); else pass_cnt++;
    chk_cnt++;
    if (data !== 8'h00) $display("FAIL midrst_data: got %h expected 00", data); else pass_cnt++;
    $display("test_reset_mid: pulses=%0d data=%h", vcount - v0, data);
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic [7:0] s;
    int sel, n;
    reset_dut();
    for (int t = 0; t < 80; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: d = 4'b1110;
        3, 4, 5: d = 4'b1101;
        6:       d = 4'b1011;
        7:       d = 4'b0111;
        default: d = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 5) == 0) s = 8'($urandom_range(0, 255));
      else s = {~glyphs[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
      n = (sel == 9) ? 1 : $urandom_range(5, 40);
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
      hold(d, s, n);
      $display("test_random: seg %0d digit=%b seg=%h hold=%0d data=%h", t, d, s, n, data);
    end
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (data !== m_data) $display("FAIL rand_final: got %h expected %h", data, m_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_short_high();
    test_bad_low();
    test_dp_glitch();
    test_reset_mid();
    test_random();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/segments_decoder.md
SEGMENTS_DECODER -- requirements
Module: segments_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, meaning the number of consecutive identical input samples required before a digit is accepted (legal range 2..1023).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port seg_data  input  8  active-low segment pattern; bit7..bit1 = a..g, bit0 = h (decimal point).
REQ-005 SHALL have port seg_digit  input  4  active-low digit select; 1110 = low nibble, 1101 = high nibble, 1011 and 0111 = blank digits.
REQ-006 SHALL have port data  output  8  last fully captured byte {high nibble, low nibble}.
REQ-007 SHALL have port valid  output  1  one-cycle pulse; data has just been updated.
REQ-008 SHALL have port err  output  1  one-cycle pulse; an accepted low or high digit carried an undecodable pattern.

Function
REQ-009 SHALL register {seg_digit, seg_data} every cycle into in_q.
REQ-010 SHALL clear the stability counter when the current input differs from in_q, and SHALL otherwise increment it, saturating at STABLE_CYCLES.
REQ-011 SHALL raise an internal accept event for exactly one cycle, when the counter equals STABLE_CYCLES-1 and the input equals in_q; a held input yields one event only.
REQ-012 SHALL decode an accepted pattern as p = ~seg_data, ignoring p[0], and match p[7:1] against the 16 hex glyphs: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-013 SHALL use a two-state FSM: S_LO (waiting for low nibble) and S_HI (low nibble held in lo_reg, waiting for high nibble).
REQ-014 In S_LO, a valid low-digit event SHALL store the nibble in lo_reg and move to S_HI; any other event SHALL leave the FSM in S_LO.
REQ-015 In S_HI, a valid high-digit event SHALL load data with {nibble, lo_reg}, pulse valid, and return to S_LO.
REQ-016 In S_HI, a valid low-digit event SHALL overwrite lo_reg and stay in S_HI.
REQ-017 In S_HI, a blank-digit event SHALL return to S_LO without updating data.
REQ-018 A low- or high-digit event with an unmatched pattern SHALL pulse err and force S_LO, in either state.
REQ-019 Events with seg_digit not in {1110, 1101, 1011, 0111} SHALL be ignored.
REQ-020 Blank-digit patterns SHALL never raise err.
REQ-021 valid SHALL go high on the clock edge numbered STABLE_CYCLES, where edge 0 is the first edge that samples the new high-digit pattern.
REQ-022 err SHALL follow the same timing as valid.
REQ-023 data SHALL hold its value between valid pulses.
REQ-024 valid and err SHALL never be high in the same cycle.

Reset
REQ-025 While rst is high, the block SHALL set data=8'h00, valid=0, err=0, FSM=S_LO, counter=0, in_q=12'hFFF and lo_reg=0.
REQ-026 Asserting rst mid-capture SHALL discard lo_reg, so a following high-digit event alone produces no valid.
REQ-027 Input stability SHALL be re-qualified from zero after reset is released.

Verification
REQ-028 Scenario 1: digit 1110/seg 0x49 then digit 1101/seg 0x11, each held 40 cycles -> exactly one valid pulse, data=8'hA5, at edge 16 of the high digit.
REQ-029 Scenario 2: full four-digit rotation (1110:0x49, 1101:0x11, 1011:0x71, 0111:0x71) repeated 3 times -> 3 valid pulses, data=8'hA5, err never high.
REQ-030 Scenario 3: low digit 0x49 held 40 cycles, then high digit 0x11 held only 10 cycles, then blank 0x71 -> no valid; FSM back in S_LO.
REQ-031 Scenario 4: low digit with seg 0xFF held 40 cycles -> one err pulse, no valid; a following 0x49/0x11 sequence -> valid with data=8'hA5.
REQ-032 Scenario 5: decimal point lit (low 0x48, high 0x10) -> data=8'hA5; a glitch toggling seg_data for 1 cycle mid-hold restarts qualification and still yields exactly one valid.
REQ-033 Scenario 6: rst pulsed one cycle after the low-digit event, then high digit 0x11 held 40 cycles -> no valid, data stays 8'h00.
